score_bcd_renderer: RTL and testbench



---
 rtl/score_bcd_renderer_pkg.sv | 35 +++
 rtl/score_bcd_renderer_if.sv | 29 ++
 rtl/score_bcd_renderer_bcd_digit.sv | 22 ++
 rtl/score_bcd_renderer.sv | 157 +++++++++++++++
 tb/tb_score_bcd_renderer.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/score_bcd_renderer_pkg.sv
// Shared segment indices and the BCD-to-seven-segment decode for the score overlay.
// Bit i of a segment mask lights segment SEG_A+i, so masks read {g,f,e,d,c,b,a}.
package score_pkg;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam logic [6:0] BLANK_SEG = 7'b000_0000;

  // Nibbles A-F never occur in a BCD counter; they fall through to an unlit glyph.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    logic [6:0] s;
    s = BLANK_SEG;
    case (d)
      4'd0:    s = 7'b011_1111;
      4'd1:    s = 7'b000_0110;
      4'd2:    s = 7'b101_1011;
      4'd3:    s = 7'b100_1111;
      4'd4:    s = 7'b110_0110;
      4'd5:    s = 7'b110_1101;
      4'd6:    s = 7'b111_1101;
      4'd7:    s = 7'b000_0111;
      4'd8:    s = 7'b111_1111;
      4'd9:    s = 7'b110_1111;
      default: s = BLANK_SEG;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/score_bcd_renderer_if.sv
// Bundle between the game FSM / VGA timing (master) and the score renderer (slave).
// i_inc and i_clear are level-sampled every clock (no valid/ready): each high cycle of
// i_inc is one increment, i_clear wins over i_inc, and o_new_high is a one-cycle pulse.
interface score_bcd_renderer_if #(
    parameter int NUM_DIGITS = 4
);

    logic [9:0]              i_hpos;
    logic [9:0]              i_vpos;
    logic                    i_inc;
    logic                    i_clear;
    logic                    i_show_high;
    logic [4*NUM_DIGITS-1:0] o_score_bcd;
    logic [4*NUM_DIGITS-1:0] o_high_bcd;
    logic                    o_saturated;
    logic                    o_new_high;
    logic [2:0]              o_score_rgb;

    modport master (
        output i_hpos, i_vpos, i_inc, i_clear, i_show_high,
        input  o_score_bcd, o_high_bcd, o_saturated, o_new_high, o_score_rgb
    );

    modport slave (
        input  i_hpos, i_vpos, i_inc, i_clear, i_show_high,
        output o_score_bcd, o_high_bcd, o_saturated, o_new_high, o_score_rgb
    );

endinterface

// File: rtl/score_bcd_renderer_bcd_digit.sv
// One decimal digit of the ripple-BCD score counter: counts 0..9 when enabled,
// wraps 9->0 and raises o_carry in the cycle it wraps.
module bcd_digit (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_clr,
    input  logic       i_en,
    output logic [3:0] o_q,
    output logic       o_carry
);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clr) begin
            o_q <= 4'd0;
        end else if (i_en) begin
            o_q <= (o_q == 4'd9) ? 4'd0 : o_q + 4'd1;
        end
    end

    assign o_carry = i_en & (o_q == 4'd9);

endmodule

// File: rtl/score_bcd_renderer.sv
// Score / high-score BCD counters rendered as seven-segment glyphs in the status bar,
// with leading-zero blanking and a registered pixel colour (one cycle of latency).
module score_bcd_renderer
    import score_pkg::*;
#(
    parameter int         NUM_DIGITS    = 4,
    parameter int         DIGIT_W       = 12,
    parameter int         DIGIT_H       = 28,
    parameter int         DIGIT_GAP     = 4,
    parameter int         H_START       = 560,
    parameter int         V_START       = 2,
    parameter int         BAR_HEIGHT    = 32,
    parameter logic [2:0] FG_RGB        = 3'b001,
    parameter logic [2:0] BG_RGB        = 3'b111,
    parameter bit         BLANK_LEADING = 1'b1
) (
    input logic                 i_clk,
    input logic                 i_rst_n,
    score_bcd_renderer_if.slave bus
);

    localparam int NW    = 4 * NUM_DIGITS;
    localparam int PITCH = DIGIT_W + DIGIT_GAP;

    localparam logic [15:0] W16   = 16'(DIGIT_W);
    localparam logic [15:0] H16   = 16'(DIGIT_H);
    localparam logic [15:0] T16   = 16'd4;
    localparam logic [15:0] M16   = 16'(DIGIT_H / 2);
    localparam logic [15:0] Y_LO  = 16'(V_START);
    localparam logic [15:0] Y_HI  = 16'(V_START + DIGIT_H);
    localparam logic [15:0] BAR16 = 16'(BAR_HEIGHT);

    // Which segments' stroke areas cover local glyph coordinate (x, y).
    function automatic logic [6:0] seg_zone(input logic [15:0] x, input logic [15:0] y);
        logic [6:0] z;
        z        = '0;
        z[SEG_A] = (y < T16);
        z[SEG_B] = (x >= W16 - T16) && (y < M16);
        z[SEG_C] = (x >= W16 - T16) && (y >= M16);
        z[SEG_D] = (y >= H16 - T16);
        z[SEG_E] = (x < T16) && (y >= M16);
        z[SEG_F] = (x < T16) && (y < M16);
        z[SEG_G] = (y >= M16 - T16 / 2) && (y < M16 + T16 / 2);
        return z;
    endfunction

    logic [NW-1:0]         score;
    logic [NW-1:0]         high;
    logic                  new_high;
    logic                  saturated;
    logic [NUM_DIGITS-1:0] nines;
    logic [NUM_DIGITS-1:0] carry;
    logic                  unused_msd_carry;

    // Score counter: digit k steps when every lower digit is 9; held once all 9s.
    assign carry[0] = bus.i_inc & ~saturated;

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
        if (k == NUM_DIGITS - 1) begin : g_msd
            bcd_digit u_digit (
                .i_clk   (i_clk),
                .i_rst_n (i_rst_n),
                .i_clr   (bus.i_clear),
                .i_en    (carry[k]),
                .o_q     (score[4*k +: 4]),
                .o_carry (unused_msd_carry)
            );
        end else begin : g_lsd
            bcd_digit u_digit (
                .i_clk   (i_clk),
                .i_rst_n (i_rst_n),
                .i_clr   (bus.i_clear),
                .i_en    (carry[k]),
                .o_q     (score[4*k +: 4]),
                .o_carry (carry[k+1])
            );
        end
        assign nines[k] = (score[4*k +: 4] == 4'd9);
    end

    assign saturated = &nines;

    // Packed BCD keeps decimal order, so a plain unsigned compare ranks the scores.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            high     <= '0;
            new_high <= 1'b0;
        end else begin
            new_high <= (score > high);
            if (score > high) begin
                high <= score;
            end
        end
    end

    logic [NW-1:0]         src;
    logic [15:0]           hpos16;
    logic [15:0]           vpos16;
    logic [15:0]           y;
    logic                  in_row;
    logic [NUM_DIGITS-1:0] upper_zero;
    logic [NUM_DIGITS-1:0] blank;
    logic [NUM_DIGITS-1:0] glyph_hit;

    assign src    = bus.i_show_high ? high : score;
    assign hpos16 = {6'd0, bus.i_hpos};
    assign vpos16 = {6'd0, bus.i_vpos};
    assign in_row = (vpos16 >= Y_LO) && (vpos16 < Y_HI);
    assign y      = vpos16 - Y_LO;

    // upper_zero[k]: digit k and every digit above it are zero.
    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_glyph
        localparam logic [15:0] X_LO = 16'(H_START + (NUM_DIGITS - 1 - k) * PITCH);

        logic        in_col;
        logic [15:0] x;

        if (k == NUM_DIGITS - 1) begin : g_top
            assign upper_zero[k] = (src[4*k +: 4] == 4'd0);
        end else begin : g_below
            assign upper_zero[k] = (src[4*k +: 4] == 4'd0) & upper_zero[k+1];
        end

        assign blank[k]     = BLANK_LEADING && upper_zero[k] && (k != 0);
        assign in_col       = (hpos16 >= X_LO) && (hpos16 < X_LO + W16);
        assign x            = hpos16 - X_LO;
        assign glyph_hit[k] = in_col & ~blank[k] &
                              (|(bcd_to_seg(src[4*k +: 4]) & seg_zone(x, y)));
    end

    logic [2:0] rgb_d;
    logic [2:0] rgb_q;

    always_comb begin
        rgb_d = BG_RGB;
        if (vpos16 >= BAR16) begin
            rgb_d = 3'b000;
        end else if (in_row && (|glyph_hit)) begin
            rgb_d = FG_RGB;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            rgb_q <= 3'b000;
        end else begin
            rgb_q <= rgb_d;
        end
    end

    assign bus.o_score_bcd = score;
    assign bus.o_high_bcd  = high;
    assign bus.o_saturated = saturated;
    assign bus.o_new_high  = new_high;
    assign bus.o_score_rgb = rgb_q;

endmodule

// File: tb/tb_score_bcd_renderer.sv
// Directed bench for score_bcd_renderer: a pixel vector table, full status-bar sweeps
// against a glyph model, and hand-written counter / high-score / saturation sequences.
module tb_score_bcd_renderer;

    localparam logic [2:0] FG = 3'b001;
    localparam logic [2:0] BG = 3'b111;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] hpos = '0;
    logic [9:0] vpos = '0;
    logic       inc = 1'b0;
    logic       clear = 1'b0;
    logic       show_high = 1'b0;

    always #5 clk = ~clk;

    score_bcd_renderer_if #(.NUM_DIGITS(4)) bus0 ();
    score_bcd_renderer_if #(.NUM_DIGITS(4)) bus1 ();

    assign bus0.i_hpos      = hpos;
    assign bus0.i_vpos      = vpos;
    assign bus0.i_inc       = inc;
    assign bus0.i_clear     = clear;
    assign bus0.i_show_high = show_high;
    assign bus1.i_hpos      = hpos;
    assign bus1.i_vpos      = vpos;
    assign bus1.i_inc       = inc;
    assign bus1.i_clear     = clear;
    assign bus1.i_show_high = show_high;

    score_bcd_renderer #(.NUM_DIGITS(4)) dut0 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus0)
    );

    score_bcd_renderer #(.NUM_DIGITS(4), .BLANK_LEADING(1'b0)) dut1 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus1)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int nh_cnt = 0;

    always @(negedge clk) begin
        if (rst_n && bus0.o_new_high === 1'b1) nh_cnt++;
    end

    // Lit segments per decimal digit, as letters a..g.
    string glyphs[10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                          "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};

    function automatic bit has_seg(input int d, input byte c);
        string s;
        if (d > 9) return 1'b0;
        s = glyphs[d];
        for (int i = 0; i < s.len(); i++) begin
            if (s[i] == c) return 1'b1;
        end
        return 1'b0;
    endfunction

    // 12x28 glyph, stroke 4, middle row 14.
    function automatic bit glyph_px(input int d, input int x, input int y);
        bit r = 1'b0;
        if (has_seg(d, "a") && y < 4) r = 1'b1;
        if (has_seg(d, "b") && x >= 8 && y < 14) r = 1'b1;
        if (has_seg(d, "c") && x >= 8 && y >= 14) r = 1'b1;
        if (has_seg(d, "d") && y >= 24) r = 1'b1;
        if (has_seg(d, "e") && x < 4 && y >= 14) r = 1'b1;
        if (has_seg(d, "f") && x < 4 && y < 14) r = 1'b1;
        if (has_seg(d, "g") && y >= 12 && y < 16) r = 1'b1;
        return r;
    endfunction

    function automatic logic [2:0] model_rgb(input logic [15:0] val, input bit blank_lead,
                                             input int h, input int v);
        if (v >= 32) return 3'b000;
        for (int d = 0; d < 4; d++) begin
            int left;
            left = 560 + (3 - d) * 16;
            if (h >= left && h < left + 12 && v >= 2 && v < 30) begin
                if (blank_lead && d > 0 && (val >> (4 * d)) == 16'd0) return BG;
                return glyph_px(int'(val[4*d +: 4]), h - left, v - 2) ? FG : BG;
            end
        end
        return BG;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_inc(input int n);
        inc = 1'b1;
        repeat (n) step();
        inc = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic pixel(input int h, input int v);
        hpos = 10'(h);
        vpos = 10'(v);
        step();
    endtask

    task automatic sweep(input string tag, input bit in_rst, input logic [15:0] val);
        for (int v = 0; v < 35; v++) begin
            for (int h = 552; h < 628; h++) begin
                pixel(h, v);
                check($sformatf("%s blank (%0d,%0d)", tag, h, v), 32'(bus0.o_score_rgb),
                      32'(in_rst ? 3'b000 : model_rgb(val, 1'b1, h, v)));
                check($sformatf("%s noblank (%0d,%0d)", tag, h, v), 32'(bus1.o_score_rgb),
                      32'(in_rst ? 3'b000 : model_rgb(val, 1'b0, h, v)));
            end
        end
    endtask

    typedef struct {
        int         h;
        int         v;
        logic [2:0] exp;
        string      name;
    } vec_t;

    vec_t vecs[18];

    initial begin
        // Pixel table for score 1234 with leading blanking (dut0).
        vecs[0]  = '{576,  3, FG, "d2 seg a"};
        vecs[1]  = '{560,  3, BG, "d3 '1' no a"};
        vecs[2]  = '{571,  3, FG, "d3 seg b"};
        vecs[3]  = '{571, 20, FG, "d3 seg c"};
        vecs[4]  = '{565, 16, BG, "d3 '1' no g"};
        vecs[5]  = '{581, 16, FG, "d2 seg g"};
        vecs[6]  = '{576, 20, FG, "d2 seg e"};
        vecs[7]  = '{587, 20, BG, "d2 '2' no c"};
        vecs[8]  = '{597, 28, FG, "d1 seg d"};
        vecs[9]  = '{592, 20, BG, "d1 '3' no e"};
        vecs[10] = '{608,  8, FG, "d0 seg f"};
        vecs[11] = '{613,  3, BG, "d0 '4' no a"};
        vecs[12] = '{572,  2, BG, "gap pixel"};
        vecs[13] = '{576, 32, 3'b000, "below bar"};
        vecs[14] = '{600,  1, BG, "above glyph row"};
        vecs[15] = '{620,  3, BG, "right of d0"};
        vecs[16] = '{581, 29, FG, "d2 bottom row"};
        vecs[17] = '{581, 30, BG, "below glyph"};

        // Held in reset: everything black, counters zero.
        repeat (3) step();
        check("reset score", 32'(bus0.o_score_bcd), 32'h0);
        check("reset high", 32'(bus0.o_high_bcd), 32'h0);
        check("reset saturated", 32'(bus0.o_saturated), 32'h0);
        check("reset new_high", 32'(bus0.o_new_high), 32'h0);
        sweep("reset sweep", 1'b1, 16'h0000);

        rst_n = 1'b1;
        step();
        sweep("zero sweep", 1'b0, 16'h0000);

        // Count to 42; high trails the score by one cycle.
        nh_cnt = 0;
        pulse_inc(42);
        check("score 42", 32'(bus0.o_score_bcd), 32'h0042);
        check("high lags at 41", 32'(bus0.o_high_bcd), 32'h0041);
        step();
        check("high 42", 32'(bus0.o_high_bcd), 32'h0042);
        check("new_high on 42", 32'(bus0.o_new_high), 32'h1);
        clear = 1'b1;
        inc   = 1'b1;
        step();
        clear = 1'b0;
        inc   = 1'b0;
        check("clear beats inc", 32'(bus0.o_score_bcd), 32'h0000);
        check("no pulse on clear", 32'(bus0.o_new_high), 32'h0);
        repeat (3) step();
        check("high kept after clear", 32'(bus0.o_high_bcd), 32'h0042);
        check("new_high pulse count", 32'(nh_cnt), 32'd42);

        // Score 0007: blanking vs no blanking.
        pulse_inc(7);
        check("score 7", 32'(bus0.o_score_bcd), 32'h0007);
        pixel(560, 3);
        check("0007 d3 blanked", 32'(bus0.o_score_rgb), 32'(BG));
        check("0007 d3 zero drawn", 32'(bus1.o_score_rgb), 32'(FG));
        pixel(608, 3);
        check("0007 d0 seg a", 32'(bus0.o_score_rgb), 32'(FG));
        pixel(608, 20);
        check("0007 d0 no e", 32'(bus0.o_score_rgb), 32'(BG));
        sweep("0007 sweep", 1'b0, 16'h0007);

        // Score 1234 and the pixel table.
        do_clear();
        pulse_inc(1234);
        check("score 1234", 32'(bus0.o_score_bcd), 32'h1234);
        step();
        check("high 1234", 32'(bus0.o_high_bcd), 32'h1234);
        for (int i = 0; i < 18; i++) begin
            pixel(vecs[i].h, vecs[i].v);
            check(vecs[i].name, 32'(bus0.o_score_rgb), 32'(vecs[i].exp));
        end

        // Render source select.
        do_clear();
        show_high = 1'b1;
        pixel(576, 3);
        check("show high d2 a", 32'(bus0.o_score_rgb), 32'(FG));
        pixel(560, 3);
        check("show high d3 '1'", 32'(bus0.o_score_rgb), 32'(BG));
        show_high = 1'b0;
        pixel(576, 3);
        check("show score d2 blank", 32'(bus0.o_score_rgb), 32'(BG));
        check("show score d2 zero", 32'(bus1.o_score_rgb), 32'(FG));

        // Saturation at 9999.
        do_clear();
        pulse_inc(9998);
        check("score 9998", 32'(bus0.o_score_bcd), 32'h9998);
        check("not saturated", 32'(bus0.o_saturated), 32'h0);
        pulse_inc(1);
        check("score 9999", 32'(bus0.o_score_bcd), 32'h9999);
        check("saturated", 32'(bus0.o_saturated), 32'h1);
        pulse_inc(2);
        check("score holds 9999", 32'(bus0.o_score_bcd), 32'h9999);
        check("still saturated", 32'(bus0.o_saturated), 32'h1);
        check("high 9999", 32'(bus0.o_high_bcd), 32'h9999);

        // Mid-frame reset blacks one pixel, rendering resumes after.
        rst_n = 1'b0;
        pixel(608, 3);
        check("mid reset black", 32'(bus0.o_score_rgb), 32'h0);
        rst_n = 1'b1;
        pixel(608, 3);
        check("after reset d0 '0'", 32'(bus0.o_score_rgb), 32'(FG));
        check("after reset score", 32'(bus0.o_score_bcd), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
